cpu_writeback: RTL
==================

# cpu_writeback

Write-side master for the moxie register file: merges execute-stage results and memory load returns into the file's single write port, one write per cycle. Execute results take priority. Load returns are buffered in a small FIFO. A 16-bit busy scoreboard tells decode which registers still have a write outstanding. Sits between execute/memory stages and `cpu_registerfile`, driving its write_enable/index/value inputs.

## Interface
- FIFO_DEPTH, 4, load-return buffer entries; power of two, ≥2
- clk_i  in  1  clock; all flops rise-edge
- rst_i  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  execute result valid; always accepted
- ex_index_i  in  4  execute destination register
- ex_value_i  in  32  execute result
- mem_valid_i  in  1  load return valid
- mem_index_i  in  4  load destination register
- mem_value_i  in  32  load data
- mem_ready_o  out  1  FIFO not full; transfer when mem_valid_i && mem_ready_o
- claim_valid_i  in  1  decode issues an instruction with a destination
- claim_index_i  in  4  destination being claimed
- busy_o  out  16  scoreboard; bit n = write to register n outstanding
- write_enable_o  out  1  to register file write_enable_i
- reg_write_index_o  out  4  to register file reg_write_index_i
- value_o  out  32  to register file value_i
- fwd_index_i  in  4  forwarding query index
- fwd_hit_o  out  1  query matches write in flight
- fwd_value_o  out  32  forwarded value

## Operation
- Reset (rst_i low, async): write_enable_o=0, reg_write_index_o=0, value_o=0, busy_o=0, FIFO empty, fwd_hit_o=0, fwd_value_o=0; mem_ready_o=1 (combinational !full).
- Select each cycle: ex_valid_i → issue ex; else FIFO non-empty → pop head and issue; else nothing.
- Issue = register {1, index, value} into write outputs; otherwise write_enable_o=0, index/value hold last.
- Load push when mem_valid_i && mem_ready_o. mem_ready_o depends only on registered count: when full, no push even if a pop occurs the same cycle.
- FIFO with push and pop in the same cycle: count unchanged, order preserved. Pop from empty never happens. Push with mem_ready_o=0 is a protocol error; the data is dropped.
- Scoreboard: claim sets bit claim_index_i; issue clears bit of the issued index. Same index set and clear in one cycle: set wins.
- WAW avoidance is decode's duty: it must not claim a busy register. Within the loads, order is FIFO order.
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

## Timing
- Execute result: ex_valid_i sampled at edge N → write_enable_o high during cycle N..N+1 → register file writes at edge N+1.
- Load, no ex contention: push at edge N, pop/issue at edge N+1, file write at edge N+2.
- A continuous ex stream starves the FIFO. Loads stall via mem_ready_o; starvation is accepted by design.
- busy_o bit clears at the issue edge, the same edge write_enable_o rises.
- Forwarding (when enabled) is combinational: covers the one cycle where busy is clear but the file is not yet written.

## Configuration
- CPU_WRITEBACK_FWD_EN defined: fwd_hit_o = write_enable_o && reg_write_index_o==fwd_index_i; fwd_value_o = value_o when hit, else 0.
- Not defined: ports remain, fwd_hit_o=0, fwd_value_o=0 constant; decode must instead stall one extra cycle after busy clears.

## Structure
- cpu_pkg holds the shared constants: REG_IDX_W=4, WORD_W=32, NUM_REGS=16; the register file uses them too.
- One sub-module, cpu_writeback_fifo: parameterised by depth, holding {index, value} entries, with push/pop/full/empty. Reset empties it asynchronously.
- Top level contains select mux, output register, scoreboard, forwarding compare.

## Test plan
- Reset mid-stream: FIFO holds 3 loads, assert rst_i low → outputs zero, busy_o=0, mem_ready_o=1; release → no spurious write.
- Ex only: claim r5, then ex r5=0xDEADBEEF → next cycle write_enable_o=1, index 5, value 0xDEADBEEF; busy_o[5] clears the same edge.
- Contention: ex r1=0x11 and load r2=0x22 in the same cycle → r1 issued first, r2 one cycle later.
- FIFO full: 5 loads back-to-back under continuous ex → mem_ready_o=0 after 4th; on ex stop the 4 loads drain in order, then mem_ready_o=1.
- Scoreboard race: issue r3 while claim r3 same cycle → busy_o[3] stays 1.
- Forwarding with CPU_WRITEBACK_FWD_EN: ex r7=0x1234, query 7 next cycle → fwd_hit_o=1, fwd_value_o=0x1234. Without the macro: fwd_hit_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths and types for the moxie register file and its
//               write-side master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int REG_IDX_W = 4;
  localparam int WORD_W    = 32;
  localparam int NUM_REGS  = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [NUM_REGS-1:0]  reg_mask_t;

  typedef struct packed {
    reg_idx_t index;
    word_t    value;
  } wb_entry_t;

  // One-hot register mask, all-zero when en is low.
  function automatic reg_mask_t idx_onehot(input reg_idx_t idx, input logic en);
    reg_mask_t mask;
    mask = '0;
    if (en) mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_writeback_fifo.sv
// ============================================================================
// Module      : cpu_writeback_fifo
// Description : Load-return buffer of {index, value} entries; DEPTH must be a
//               power of two >= 2. Push is ignored when full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_writeback_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wb_entry_t i_push_data,
  input  logic      i_pop,
  output wb_entry_t o_pop_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  wb_entry_t          r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full     = (r_count == c_DEPTH);
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Pointers rely on power-of-two depth to wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/cpu_writeback.sv
// ============================================================================
// Module      : cpu_writeback
// Description : Merges execute results and buffered load returns onto the
//               register file's single write port; tracks pending writes.
//               Optional forwarding enabled by macro CPU_WRITEBACK_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_writeback
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  input  logic [REG_IDX_W-1:0] ex_index_i,
  input  logic [WORD_W-1:0]    ex_value_i,
  input  logic                 mem_valid_i,
  input  logic [REG_IDX_W-1:0] mem_index_i,
  input  logic [WORD_W-1:0]    mem_value_i,
  output logic                 mem_ready_o,
  input  logic                 claim_valid_i,
  input  logic [REG_IDX_W-1:0] claim_index_i,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic                 write_enable_o,
  output logic [REG_IDX_W-1:0] reg_write_index_o,
  output logic [WORD_W-1:0]    value_o,
  input  logic [REG_IDX_W-1:0] fwd_index_i,
  output logic                 fwd_hit_o,
  output logic [WORD_W-1:0]    fwd_value_o
);

  wb_entry_t w_push_data;
  wb_entry_t w_head;
  logic      w_fifo_full;
  logic      w_fifo_empty;
  logic      w_pop;
  logic      w_issue;
  reg_idx_t  w_issue_idx;
  word_t     w_issue_val;

  logic      r_we;
  reg_idx_t  r_idx;
  word_t     r_val;
  reg_mask_t r_busy;

  assign w_push_data = '{index: mem_index_i, value: mem_value_i};

  cpu_writeback_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk_i),
    .rst_n       (rst_i),
    .i_push      (mem_valid_i),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign mem_ready_o = !w_fifo_full;

  // Execute always wins the port; loads only drain on idle execute cycles.
  assign w_pop       = !ex_valid_i && !w_fifo_empty;
  assign w_issue     = ex_valid_i || !w_fifo_empty;
  assign w_issue_idx = ex_valid_i ? ex_index_i : w_head.index;
  assign w_issue_val = ex_valid_i ? ex_value_i : w_head.value;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we  <= 1'b0;
      r_idx <= '0;
      r_val <= '0;
    end else begin
      r_we <= w_issue;
      if (w_issue) begin
        r_idx <= w_issue_idx;
        r_val <= w_issue_val;
      end
    end
  end

  // Set after clear so a same-cycle claim of the issued register stays busy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~idx_onehot(w_issue_idx, w_issue))
              | idx_onehot(claim_index_i, claim_valid_i);
    end
  end

  assign write_enable_o    = r_we;
  assign reg_write_index_o = r_idx;
  assign value_o           = r_val;
  assign busy_o            = r_busy;

`ifdef CPU_WRITEBACK_FWD_EN
  logic w_fwd_hit;
  assign w_fwd_hit   = r_we && (r_idx == fwd_index_i);
  assign fwd_hit_o   = w_fwd_hit;
  assign fwd_value_o = w_fwd_hit ? r_val : '0;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_index_i;
  assign fwd_hit_o    = 1'b0;
  assign fwd_value_o  = '0;
`endif

endmodule

`default_nettype wire
